// File: rtl/ring_pkg.sv
// Shared types and constants for the ring-stop link blocks.
package ring_pkg;

    // Default flit width; top-level ports follow the WIDTH parameter.
    localparam int unsigned FLIT_W = 64;

    // Credit and starvation counters share this width (limits are 1..15).
    localparam int unsigned CRD_W = 4;

    typedef logic [FLIT_W-1:0] flit_t;

    typedef enum logic {
        PASS_PRI,
        LOC_FORCE
    } arb_state_e;

endpackage

// File: rtl/ring_credit_cnt.sv
// Credit counter: take/return accounting, saturating at MAX, with a sticky
// overflow flag for a return that arrives while already full.
module ring_credit_cnt import ring_pkg::*; #(
    parameter int unsigned MAX = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iTake,
    input  logic             iRet,
    output logic [CRD_W-1:0] oCount,
    output logic             oErr
);

    localparam logic [CRD_W-1:0] MaxCnt = CRD_W'(MAX);
    localparam logic [CRD_W-1:0] One    = CRD_W'(1);

    logic [CRD_W-1:0] countQ;
    logic             errQ;

    // Simultaneous take and return cancel; a lone return at full only flags overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            countQ <= MaxCnt;
            errQ   <= 1'b0;
        end else if (iTake && !iRet) begin
            countQ <= countQ - One;
        end else if (iRet && !iTake) begin
            if (countQ == MaxCnt) begin
                errQ <= 1'b1;
            end else begin
                countQ <= countQ + One;
            end
        end
    end

    assign oCount = countQ;
    assign oErr   = errQ;

endmodule

// File: rtl/ring_link_tx.sv
// Ring-stop transmit side: arbitrates pass-through and local flits onto one
// credit-controlled link, ring first, with a starvation guard for local.
module ring_link_tx import ring_pkg::*; #(
    parameter int unsigned WIDTH        = 64,
    parameter int unsigned CREDITS      = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iPassVld,
    input  logic [WIDTH-1:0] iPassDat,
    output logic             oPassRdEn,
    input  logic             iLocVld,
    input  logic [WIDTH-1:0] iLocDat,
    output logic             oLocRdy,
    output logic             oLinkVld,
    output logic [WIDTH-1:0] oLinkDat,
    input  logic             iCreditRet,
    output logic [CRD_W-1:0] oCredits,
    output logic             oErr
);

    localparam logic [CRD_W-1:0] StarveLim = CRD_W'(STARVE_LIMIT);
    localparam logic [CRD_W-1:0] StarveMax = '1;
    localparam logic [CRD_W-1:0] One       = CRD_W'(1);

    arb_state_e       stateQ;
    logic [CRD_W-1:0] starveQ;
    logic [CRD_W-1:0] starveD;
    logic             linkVldQ;
    logic [WIDTH-1:0] linkDatQ;

    logic             canSend;
    logic             passGnt;
    logic             locGnt;
    logic             anyGnt;

    assign canSend = (oCredits != '0);

    // Priority grant; at most one source per cycle and only with a credit in hand.
    always_comb begin
        passGnt = 1'b0;
        locGnt  = 1'b0;
        if (canSend) begin
            unique case (stateQ)
                PASS_PRI: begin
                    passGnt = iPassVld;
                    locGnt  = iLocVld && !iPassVld;
                end
                LOC_FORCE: begin
                    locGnt  = iLocVld;
                    passGnt = iPassVld && !iLocVld;
                end
            endcase
        end
    end

    assign anyGnt    = passGnt || locGnt;
    assign oPassRdEn = passGnt;
    assign oLocRdy   = locGnt;

    // Count pass grants taken while local waits; cleared once local moves or leaves.
    always_comb begin
        starveD = starveQ;
        if (!iLocVld || locGnt) begin
            starveD = '0;
        end else if (passGnt && starveQ != StarveMax) begin
            starveD = starveQ + One;
        end
    end

    // Arbiter state, starvation count and the registered link stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ   <= PASS_PRI;
            starveQ  <= '0;
            linkVldQ <= 1'b0;
            linkDatQ <= '0;
        end else begin
            starveQ  <= starveD;
            linkVldQ <= anyGnt;
            if (anyGnt) begin
                linkDatQ <= passGnt ? iPassDat : iLocDat;
            end
            unique case (stateQ)
                PASS_PRI: begin
                    // Switch on the pass grant that brings the count to the limit.
                    if (iLocVld && starveD >= StarveLim) begin
                        stateQ <= LOC_FORCE;
                    end
                end
                LOC_FORCE: begin
                    if (locGnt || !iLocVld) begin
                        stateQ <= PASS_PRI;
                    end
                end
            endcase
        end
    end

    assign oLinkVld = linkVldQ;
    assign oLinkDat = linkDatQ;

    ring_credit_cnt #(
        .MAX (CREDITS)
    ) uCredit (
        .clk    (clk),
        .rst    (rst),
        .iTake  (anyGnt),
        .iRet   (iCreditRet),
        .oCount (oCredits),
        .oErr   (oErr)
    );

endmodule

// File: tb/tb_ring_link_tx.sv
// Self-checking bench for ring_link_tx: directed scenarios with literal
// expectations plus a randomized run against a behavioural model.
module tb_ring_link_tx;

    localparam int unsigned WIDTH        = 64;
    localparam int unsigned CREDITS      = 2;
    localparam int unsigned STARVE_LIMIT = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             passVld = 1'b0;
    logic [WIDTH-1:0] passDat = '0;
    logic             passRdEn;
    logic             locVld = 1'b0;
    logic [WIDTH-1:0] locDat = '0;
    logic             locRdy;
    logic             linkVld;
    logic [WIDTH-1:0] linkDat;
    logic             creditRet = 1'b0;
    logic [3:0]       credits;
    logic             err;

    ring_link_tx #(
        .WIDTH        (WIDTH),
        .CREDITS      (CREDITS),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .iPassVld   (passVld),
        .iPassDat   (passDat),
        .oPassRdEn  (passRdEn),
        .iLocVld    (locVld),
        .iLocDat    (locDat),
        .oLocRdy    (locRdy),
        .oLinkVld   (linkVld),
        .oLinkDat   (linkDat),
        .iCreditRet (creditRet),
        .oCredits   (credits),
        .oErr       (err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: credits in hand, overflow flag, pass grants in a row
    // while local waits, and what the link register must show.
    int               mCred;
    bit               mErr;
    int               mStreak;
    bit               mLinkVld;
    logic [WIDTH-1:0] mLinkDat;

    logic [WIDTH-1:0] up[$];
    bit               locTaken;
    bit               dutPass;
    bit               dutLoc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mCred    = CREDITS;
        mErr     = 1'b0;
        mStreak  = 0;
        mLinkVld = 1'b0;
        mLinkDat = '0;
    endtask

    // Asynchronous reset: assert off-edge, check at once, release on a falling edge.
    task automatic doReset();
        rst = 1'b1;
        #1;
        modelReset();
        chk("rst_linkVld", 64'(linkVld), 64'(0));
        chk("rst_linkDat", linkDat, 64'(0));
        chk("rst_credits", 64'(credits), 64'(CREDITS));
        chk("rst_err", 64'(err), 64'(0));
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One cycle: called at a falling edge with locVld/locDat/creditRet set.
    task automatic tick();
        bit localFirst;
        bit ePass;
        bit eLoc;
        bit gnt;
        passVld = (up.size() != 0);
        passDat = (up.size() != 0) ? up[0] : '0;
        #1;
        // Local goes first once it has watched STARVE_LIMIT pass grants in a row.
        localFirst = (mStreak >= STARVE_LIMIT);
        ePass = 1'b0;
        eLoc  = 1'b0;
        if (mCred != 0) begin
            if (localFirst) begin
                eLoc  = locVld;
                ePass = passVld && !locVld;
            end else begin
                ePass = passVld;
                eLoc  = locVld && !passVld;
            end
        end
        gnt     = ePass || eLoc;
        dutPass = passRdEn;
        dutLoc  = locRdy;
        chk("passRdEn", 64'(passRdEn), 64'(ePass));
        chk("locRdy", 64'(locRdy), 64'(eLoc));
        chk("linkVld", 64'(linkVld), 64'(mLinkVld));
        chk("linkDat", linkDat, mLinkDat);
        chk("credits", 64'(credits), 64'(mCred));
        chk("err", 64'(err), 64'(mErr));
        mLinkVld = gnt;
        if (gnt) mLinkDat = ePass ? passDat : locDat;
        if (gnt && !creditRet) begin
            mCred--;
        end else if (!gnt && creditRet) begin
            if (mCred == CREDITS) mErr = 1'b1;
            else mCred++;
        end
        if (!locVld || eLoc) mStreak = 0;
        else if (ePass) mStreak++;
        if (ePass) void'(up.pop_front());
        if (eLoc) locTaken = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        byte   pat[10];
        string expPat;

        #1;
        modelReset();
        doReset();

        // Pass-only stream, no returns: A and B go out, C stalls on zero credits.
        up = {};
        up.push_back(64'hAAAA_0000_0000_000A);
        up.push_back(64'hBBBB_0000_0000_000B);
        up.push_back(64'hCCCC_0000_0000_000C);
        locVld = 1'b0;
        creditRet = 1'b0;
        tick();
        chk("t1_vldA", 64'(linkVld), 64'(1));
        chk("t1_datA", linkDat, 64'hAAAA_0000_0000_000A);
        chk("t1_cred1", 64'(credits), 64'(1));
        tick();
        chk("t1_datB", linkDat, 64'hBBBB_0000_0000_000B);
        chk("t1_cred0", 64'(credits), 64'(0));
        tick();
        chk("t1_idle", 64'(linkVld), 64'(0));
        chk("t1_stallC", 64'(passRdEn), 64'(0));

        // Returns every cycle: after the refill cycle, one flit per cycle at credit 1.
        creditRet = 1'b1;
        for (int k = 0; k < 8; k++) begin
            up.push_back({$urandom, $urandom});
            tick();
            if (k >= 1) begin
                chk("t2_fullrate", 64'(linkVld), 64'(1));
                chk("t2_cred1", 64'(credits), 64'(1));
            end
        end
        chk("t2_noErr", 64'(err), 64'(0));
        creditRet = 1'b0;

        // Both sources busy, credits returned each cycle: P,P,P,P,L repeating.
        doReset();
        up = {};
        locVld = 1'b1;
        locDat = {$urandom, $urandom};
        locTaken = 1'b0;
        creditRet = 1'b1;
        for (int k = 0; k < 10; k++) begin
            while (up.size() < 2) up.push_back({$urandom, $urandom});
            if (locTaken) begin
                locDat = {$urandom, $urandom};
                locTaken = 1'b0;
            end
            tick();
            pat[k] = dutPass ? 8'h50 : (dutLoc ? 8'h4c : 8'h2d);
        end
        expPat = "PPPPLPPPPL";
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("t3_pat%0d", k), 64'(pat[k]), 64'(expPat[k]));
        end

        // Zero credits with a return pending: no grant, then a pass grant at credit 1.
        doReset();
        up = {};
        for (int k = 0; k < 4; k++) up.push_back({$urandom, $urandom});
        locVld = 1'b1;
        locDat = 64'h1111_2222_3333_4444;
        locTaken = 1'b0;
        creditRet = 1'b0;
        tick();
        tick();
        creditRet = 1'b1;
        tick();
        chk("t4_noGrant", {62'd0, dutPass, dutLoc}, 64'(0));
        chk("t4_cred1", 64'(credits), 64'(1));
        creditRet = 1'b0;
        tick();
        chk("t4_passGrant", 64'(dutPass), 64'(1));

        // Return at full credits: sticky overflow, count stays at the maximum.
        doReset();
        up = {};
        locVld = 1'b0;
        creditRet = 1'b1;
        tick();
        chk("t5_err", 64'(err), 64'(1));
        chk("t5_cred", 64'(credits), 64'(CREDITS));
        creditRet = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        chk("t5_sticky", 64'(err), 64'(1));

        // Reset mid-flight with credits at 0, then resume.
        doReset();
        up = {};
        up.push_back(64'hD0D0_0000_0000_0001);
        up.push_back(64'hD0D0_0000_0000_0002);
        up.push_back(64'hD0D0_0000_0000_0003);
        tick();
        tick();
        chk("t6_inflight", 64'(linkVld), 64'(1));
        chk("t6_cred0", 64'(credits), 64'(0));
        #2;
        doReset();
        tick();
        chk("t6_resume", linkDat, 64'hD0D0_0000_0000_0003);

        // Randomized traffic against the model, with one reset in the middle.
        up = {};
        locVld = 1'b0;
        locTaken = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) begin
                #2;
                doReset();
            end
            if (up.size() < 2 && $urandom_range(0, 2) != 0) up.push_back({$urandom, $urandom});
            if (locTaken || !locVld) begin
                locVld = ($urandom_range(0, 2) != 0);
                locDat = {$urandom, $urandom};
                locTaken = 1'b0;
            end else if ($urandom_range(0, 15) == 0) begin
                locVld = 1'b0;
            end
            if (mCred < CREDITS) creditRet = ($urandom_range(0, 1) != 0);
            else creditRet = ($urandom_range(0, 63) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ring_link_tx.md
Name: ring_link_tx

Overview:
- Transmit side of a ring-stop link. Merges two sources onto one outgoing ring link with a registered output:
  - pass-through flits, popped from the upstream two-entry stop FIFO;
  - locally injected flits.
- Flow control is credit-based. Credits match the depth of the two-entry FIFO at the downstream stop, so the link can never overrun it.
- Ring traffic has priority. A starvation guard bounds how long local injection can wait.

Parameters:
- WIDTH, 64, flit width in bits.
- CREDITS, 2, downstream FIFO depth = initial credit count (1..15).
- STARVE_LIMIT, 4, max consecutive pass grants while local is pending (1..15).

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- iPassVld  input  1  upstream stop FIFO holds a flit (i.e. not empty).
- iPassDat  input  WIDTH  head flit of upstream stop FIFO.
- oPassRdEn  output  1  pop upstream FIFO this cycle; combinational.
- iLocVld  input  1  local flit offered.
- iLocDat  input  WIDTH  local flit.
- oLocRdy  output  1  local flit accepted this cycle; combinational, valid/ready.
- oLinkVld  output  1  flit on link (downstream FIFO write enable); registered.
- oLinkDat  output  WIDTH  flit on link; registered.
- iCreditRet  input  1  downstream popped one entry; one credit returned.
- oCredits  output  4  current credit count.
- oErr  output  1  sticky credit overflow.

Behaviour:
- Reset (async, any cycle, including mid-transfer):
  - oLinkVld=0, oLinkDat=0, oCredits=CREDITS, oErr=0;
  - starve counter=0; FSM=PASS_PRI.
  - Downstream FIFO resets together with this block, so no credit is stranded.
- Send eligibility: canSend = (oCredits != 0).
- FSM, 2 states:
  - PASS_PRI: grant pass if iPassVld, else grant local if iLocVld.
  - LOC_FORCE: grant local if iLocVld, else grant pass if iPassVld.
- Grants:
  - At most one grant per cycle, and only when canSend.
  - Pass grant: oPassRdEn=1.
  - Local grant: oLocRdy=1.
  - oPassRdEn and oLocRdy are never both 1.
- Starve counter (only while iLocVld=1):
  - increments on each pass grant;
  - resets on any local grant, or when iLocVld=0.
- FSM transitions:
  - PASS_PRI -> LOC_FORCE when the counter reaches STARVE_LIMIT and iLocVld=1.
  - LOC_FORCE -> PASS_PRI after one local grant, or when iLocVld drops.
- Link output:
  - Granted flit appears on oLinkDat with oLinkVld=1 the cycle after the grant (1-cycle latency).
  - oLinkVld=0 when there was no grant. oLinkDat holds its last value when idle.
- Credits:
  - decrement on a grant cycle; increment on iCreditRet;
  - both in the same cycle: unchanged.
  - Credit 0 with iCreditRet=1: a grant is not allowed that cycle. Credit is 1 next cycle.
  - Back-to-back full-rate sends are allowed while credits remain.
- Overflow: iCreditRet at oCredits==CREDITS with no grant that cycle sets oErr=1 (sticky until reset). Count saturates at CREDITS.
- Upstream empty and local idle: no grant, credits unchanged.

Decomposition:
- Shared package ring_pkg:
  - flit typedef (logic [WIDTH-1:0]);
  - arb_state_e enum {PASS_PRI, LOC_FORCE};
  - credit counter width constant CRD_W=4.
- Natural sub-module: ring_credit_cnt (counter, saturation, overflow flag), so the receive side can reuse it for return accounting.

Test Plan:
- Reset, then pass-only stream, no credit return: iPassVld=1 with flits A, B, C.
  -> oLinkVld high 2 cycles carrying A, B; credits 2->1->0; third flit stalled with oPassRdEn=0.
- Continuous pass stream with iCreditRet every cycle after the first two sends.
  -> one flit per cycle sustained; credits stay at 1 or 0; no oErr.
- iPassVld=1 and iLocVld=1 continuously, credits returned each cycle, STARVE_LIMIT=4.
  -> grant pattern P,P,P,P,L repeating; local accepted within 5 cycles.
- Credit 0, iCreditRet=1 while both sources are valid.
  -> no grant that cycle; next cycle credit=1 and a pass grant.
- Extra iCreditRet at full credits (2).
  -> oErr=1 next cycle and stays 1; oCredits remains 2.
- rst pulsed asynchronously between clock edges with a flit in flight and credits=0.
  -> oLinkVld=0, oCredits=2, FSM=PASS_PRI immediately; normal operation resumes after release.
